// File: rtl/ae_pkg.sv
// ae_pkg: shared definitions for the ae_seq_core sequencer.
//   - opcode encodings (4-bit op field at the top of each instruction word)
//   - sequencer FSM state encoding
//   - saturate(): clamp a wide signed value into a signed w-bit range
package ae_pkg;

   localparam logic [3:0] OP_NOP     = 4'd0;
   localparam logic [3:0] OP_ADD     = 4'd1;
   localparam logic [3:0] OP_SUB     = 4'd2;
   localparam logic [3:0] OP_MUL     = 4'd3;
   localparam logic [3:0] OP_RELU    = 4'd4;
   localparam logic [3:0] OP_SIG     = 4'd5;
   localparam logic [3:0] OP_SIGD    = 4'd6;
   localparam logic [3:0] OP_MOV     = 4'd7;
   localparam logic [3:0] OP_BNZ     = 4'd13;
   localparam logic [3:0] OP_SETLOOP = 4'd14;
   localparam logic [3:0] OP_HALT    = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Callers sign-extend their intermediate into 64 bits and keep the low w bits.
   function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                   input int unsigned w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi)      return hi;
      else if (v < lo) return lo;
      else             return v;
   endfunction

endpackage

// File: rtl/ae_alu_act.sv
// ae_alu_act: combinational arithmetic / activation unit for ops 1-7.
//   op  in  4       opcode (values outside 1-7 give 0)
//   a   in  DATA_W  rs1 operand, signed fixed point
//   b   in  DATA_W  rs2 operand, signed fixed point
//   y   out DATA_W  result, saturated to the signed DATA_W range
module ae_alu_act
   import ae_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8
) (
   input  logic [3:0]               op,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic signed [DATA_W-1:0] y
);

   // Two guard bits above a full product so SIGD's (ONE - a) term cannot wrap.
   localparam int PW = 2*DATA_W + 2;
   localparam logic signed [PW-1:0] ONE  = PW'(2**FRAC_W);
   localparam logic signed [PW-1:0] HALF = PW'(2**(FRAC_W-1));

   logic signed [PW-1:0] aw;
   logic signed [PW-1:0] bw;
   logic signed [PW-1:0] r;
   logic signed [63:0]   sat_v;

   always_comb begin
      aw = PW'(a);
      bw = PW'(b);
      r  = '0;
      case (op)
         OP_ADD:  r = aw + bw;
         OP_SUB:  r = aw - bw;
         OP_MUL:  r = (aw * bw) >>> FRAC_W;
         OP_RELU: r = a[DATA_W-1] ? '0 : aw;
         OP_SIG: begin
            // hard sigmoid: slope 1/4 around ONE/2, clamped to [0, ONE]
            r = (aw >>> 2) + HALF;
            if (r[PW-1])     r = '0;
            else if (r > ONE) r = ONE;
         end
         OP_SIGD: r = (aw * (ONE - aw)) >>> FRAC_W;
         OP_MOV:  r = aw;
         default: r = '0;
      endcase
      sat_v = saturate(64'(r), DATA_W);
      y     = sat_v[DATA_W-1:0];
   end

endmodule

// File: rtl/ae_seq_core.sv
// ae_seq_core: self-sequencing fixed-point core. Runs a program from imem
// over a 2**ADDR_W register file, two cycles per instruction (FETCH, EXEC).
//   clock, reset             rising-edge clock, synchronous active-high reset
//   start                    begin a run at pc=0 (only honoured in IDLE)
//   busy                     high while FETCH/EXEC
//   done                     one-cycle pulse in the cycle after HALT executes
//   err                      sticky illegal-opcode flag, cleared by accepted start
//   imem_we/addr/wdata       host program load (dropped while busy)
//   dmem_we/addr/wdata       host register write (dropped while busy)
//   dmem_rdata               registered read of dmem_addr, one cycle latency
module ae_seq_core
   import ae_pkg::*;
#(
   parameter  int DATA_W  = 16,
   parameter  int FRAC_W  = 8,
   parameter  int ADDR_W  = 4,
   parameter  int PC_W    = 8,
   localparam int INSTR_W = 4 + 3*ADDR_W
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               err,
   input  logic               imem_we,
   input  logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_wdata,
   input  logic               dmem_we,
   input  logic [ADDR_W-1:0]  dmem_addr,
   output logic [DATA_W-1:0]  dmem_rdata,
   input  logic [DATA_W-1:0]  dmem_wdata
);

   localparam int IMM_W = 3*ADDR_W;

   state_t                   state_q, state_d;
   logic [PC_W-1:0]          pc_q;
   logic [IMM_W-1:0]         loop_cnt_q;
   logic [INSTR_W-1:0]       instr_q;
   logic                     err_q;

   logic [INSTR_W-1:0]       imem [2**PC_W];
   logic signed [DATA_W-1:0] rf   [2**ADDR_W];

   logic [3:0]               op;
   logic [ADDR_W-1:0]        rs1, rs2, rd;
   logic [IMM_W-1:0]         imm;
   logic [PC_W-1:0]          pc_inc, br_tgt;
   logic signed [DATA_W-1:0] alu_y;
   logic                     exec, rf_we_core;

   // Field decode of the latched instruction: {op, rs1, rs2, rd}; the three
   // register fields double as one immediate for BNZ / SETLOOP.
   assign op         = instr_q[INSTR_W-1 -: 4];
   assign rs1        = instr_q[3*ADDR_W-1 -: ADDR_W];
   assign rs2        = instr_q[2*ADDR_W-1 -: ADDR_W];
   assign rd         = instr_q[ADDR_W-1:0];
   assign imm        = instr_q[IMM_W-1:0];
   assign pc_inc     = pc_q + PC_W'(1);
   assign br_tgt     = PC_W'(imm);
   assign exec       = (state_q == ST_EXEC);
   assign rf_we_core = exec && (op inside {[OP_ADD:OP_MOV]});
   assign err        = err_q;

   // Operands come straight off the register file, so rd==rs1 reads the old
   // value and the write lands at the end of EXEC.
   ae_alu_act #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_alu (
      .op (op),
      .a  (rf[rs1]),
      .b  (rf[rs2]),
      .y  (alu_y)
   );

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_FETCH;
         ST_FETCH: begin
            busy    = 1'b1;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            busy    = 1'b1;
            state_d = (op == OP_HALT) ? ST_DONE : ST_FETCH;
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         pc_q       <= '0;
         loop_cnt_q <= '0;
         instr_q    <= '0;
         err_q      <= 1'b0;
         dmem_rdata <= '0;
      end else begin
         state_q    <= state_d;
         dmem_rdata <= rf[dmem_addr];
         case (state_q)
            ST_IDLE: if (start) begin
               pc_q  <= '0;
               err_q <= 1'b0;
            end
            ST_FETCH: instr_q <= imem[pc_q];
            ST_EXEC: begin
               case (op)
                  OP_BNZ: begin
                     if (loop_cnt_q != '0) begin
                        loop_cnt_q <= loop_cnt_q - IMM_W'(1);
                        pc_q       <= br_tgt;
                     end else begin
                        pc_q <= pc_inc;
                     end
                  end
                  OP_SETLOOP: begin
                     loop_cnt_q <= imm;
                     pc_q       <= pc_inc;
                  end
                  OP_HALT: pc_q <= pc_q;
                  default: begin
                     // 8-12 are undefined: behave as NOP but flag it
                     if (op inside {[4'd8:4'd12]}) err_q <= 1'b1;
                     pc_q <= pc_inc;
                  end
               endcase
            end
            default: ;
         endcase
      end
   end

   // Storage arrays: not reset. Host and core share one write port; the
   // core only writes during EXEC, when host writes are dropped anyway.
   always_ff @(posedge clock) begin
      if (imem_we && !busy) imem[imem_addr] <= imem_wdata;
      if (rf_we_core)               rf[rd]        <= alu_y;
      else if (dmem_we && !busy)    rf[dmem_addr] <= dmem_wdata;
   end

endmodule

// File: tb/tb_ae_seq_core.sv
// tb_ae_seq_core: directed programs for ae_seq_core with an instruction-level
// reference model (plain integer arithmetic) predicting register contents,
// run length and err timing; a per-cycle monitor checks busy/done/err.
module tb_ae_seq_core;

   logic        clock, reset, start, busy, done, err;
   logic        imem_we, dmem_we;
   logic [7:0]  imem_addr;
   logic [15:0] imem_wdata;
   logic [3:0]  dmem_addr;
   logic [15:0] dmem_rdata, dmem_wdata;

   ae_seq_core #(.DATA_W(16), .FRAC_W(8), .ADDR_W(4), .PC_W(8)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_rdata (dmem_rdata),
      .dmem_wdata (dmem_wdata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;

   // reference state
   logic [15:0] m_im [256];
   logic [15:0] m_rf [16];
   int          m_loop;

   // monitor state
   bit mon_en = 1'b0;
   int mon_cyc, mon_n, mon_errc, mon_done_cyc;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] ins(input int op, input int s1, input int s2, input int d);
      return {op[3:0], s1[3:0], s2[3:0], d[3:0]};
   endfunction

   function automatic logic [15:0] insi(input int op, input int imm);
      return {op[3:0], imm[11:0]};
   endfunction

   task automatic wr_im(input int a, input logic [15:0] w);
      @(negedge clock);
      imem_we = 1'b1; imem_addr = a[7:0]; imem_wdata = w;
      @(negedge clock);
      imem_we = 1'b0;
      m_im[a[7:0]] = w;
   endtask

   task automatic wr_rf(input int a, input logic [15:0] d);
      @(negedge clock);
      dmem_we = 1'b1; dmem_addr = a[3:0]; dmem_wdata = d;
      @(negedge clock);
      dmem_we = 1'b0;
      m_rf[a[3:0]] = d;
   endtask

   // Reads a register back; compares against a hand-derived literal and the model.
   task automatic rd_chk(input string nm, input int a, input logic [15:0] lit);
      @(negedge clock);
      dmem_addr = a[3:0];
      @(negedge clock);
      chk(nm, dmem_rdata, lit);
      chk({nm, "_model"}, dmem_rdata, m_rf[a[3:0]]);
   endtask

   // Instruction-level execution of the program from pc 0 until HALT.
   // n = instructions executed; errc = first cycle err should read high.
   task automatic model_run(output int n, output int errc);
      logic [7:0]  pc;
      logic [15:0] w;
      int          op;
      longint      a, b, r;
      bit          wr;
      pc = 8'd0; n = 0; errc = 1 << 30;
      while (n < 5000) begin
         w  = m_im[pc];
         op = int'(w[15:12]);
         a  = longint'($signed(m_rf[w[11:8]]));
         b  = longint'($signed(m_rf[w[7:4]]));
         n++;
         wr = 1'b1;
         r  = 0;
         case (op)
            1: r = a + b;
            2: r = a - b;
            3: r = (a * b) >>> 8;
            4: r = (a < 0) ? 0 : a;
            5: begin
               r = (a >>> 2) + 128;
               if (r < 0)   r = 0;
               if (r > 256) r = 256;
            end
            6: r = (a * (256 - a)) >>> 8;
            7: r = a;
            default: wr = 1'b0;
         endcase
         if (wr) begin
            if (r > 32767)  r = 32767;
            if (r < -32768) r = -32768;
            m_rf[w[3:0]] = r[15:0];
         end
         if (op >= 8 && op <= 12 && errc == (1 << 30)) errc = 2*n + 1;
         if (op == 13) begin
            if (m_loop != 0) begin
               m_loop--;
               pc = w[7:0];
            end else pc++;
         end else if (op == 14) begin
            m_loop = int'(w[11:0]);
            pc++;
         end else if (op == 15) break;
         else pc++;
      end
   endtask

   // Cycle k after the accepted start: busy for 1..2n, done at 2n+1.
   always @(negedge clock) begin
      if (mon_en) begin
         mon_cyc++;
         chk("mon_busy", busy, (mon_cyc >= 1 && mon_cyc <= 2*mon_n));
         chk("mon_done", done, (mon_cyc == 2*mon_n + 1));
         chk("mon_err",  err,  (mon_cyc >= mon_errc));
         if (done) mon_done_cyc = mon_cyc;
         if (mon_cyc >= 2*mon_n + 2) mon_en = 1'b0;
      end
   end

   // poke=1 additionally drives start and host writes mid-run / in DONE.
   task automatic run(input bit poke);
      int n, errc;
      model_run(n, errc);
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      mon_n = n; mon_errc = errc; mon_cyc = 0; mon_done_cyc = -1; mon_en = 1'b1;
      for (int c = 1; c <= 2*n + 2; c++) begin
         @(negedge clock);
         start = 1'b0; dmem_we = 1'b0; imem_we = 1'b0;
         if (poke && c == 2) begin
            start = 1'b1;
            dmem_we = 1'b1; dmem_addr = 4'd15; dmem_wdata = 16'h1234;
            imem_we = 1'b1; imem_addr = 8'd1; imem_wdata = 16'h0000;
         end
         if (poke && c == 2*n + 1) start = 1'b1;
      end
      @(negedge clock);
      start = 1'b0; dmem_we = 1'b0; imem_we = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; imem_we = 1'b0; dmem_we = 1'b0;
      imem_addr = '0; imem_wdata = '0; dmem_addr = '0; dmem_wdata = '0;
      m_loop = 0;
      repeat (3) @(negedge clock);
      chk("rst_busy",  busy, 0);
      chk("rst_done",  done, 0);
      chk("rst_err",   err, 0);
      chk("rst_rdata", dmem_rdata, 0);
      reset = 1'b0;

      for (int i = 0; i < 256; i++) wr_im(i, 16'hF000);
      for (int i = 0; i < 16; i++)  wr_rf(i, 16'h0000);

      // basic add, latency
      wr_rf(1, 16'h0180); wr_rf(2, 16'h0100);
      wr_im(0, ins(1, 1, 2, 3)); wr_im(1, ins(15, 0, 0, 0));
      run(1'b0);
      chk("t1_done_cycle", mon_done_cyc, 5);
      chk("t1_err", err, 0);
      rd_chk("t1_r3", 3, 16'h0280);

      // saturation
      wr_rf(4, 16'h7F00); wr_rf(5, 16'h7F00); wr_rf(7, 16'h8000);
      wr_rf(8, 16'h0100); wr_rf(10, 16'h0200);
      wr_im(0, ins(1, 4, 5, 6)); wr_im(1, ins(2, 7, 8, 9));
      wr_im(2, ins(3, 7, 10, 11)); wr_im(3, ins(15, 0, 0, 0));
      run(1'b0);
      rd_chk("t2_add_sat", 6, 16'h7FFF);
      rd_chk("t2_sub_sat", 9, 16'h8000);
      rd_chk("t2_mul_sat", 11, 16'h8000);

      // activations, plus rd==rs1
      wr_rf(1, 16'hFF00); wr_rf(2, 16'h0000); wr_rf(3, 16'h0400); wr_rf(4, 16'h0080);
      wr_im(0, ins(4, 1, 0, 5)); wr_im(1, ins(5, 2, 0, 6)); wr_im(2, ins(5, 3, 0, 7));
      wr_im(3, ins(6, 4, 0, 8)); wr_im(4, ins(1, 1, 1, 1)); wr_im(5, ins(15, 0, 0, 0));
      run(1'b0);
      rd_chk("t3_relu",  5, 16'h0000);
      rd_chk("t3_sig0",  6, 16'h0080);
      rd_chk("t3_sigcl", 7, 16'h0100);
      rd_chk("t3_sigd",  8, 16'h0040);
      rd_chk("t3_rd_eq_rs1", 1, 16'hFE00);

      // loop
      wr_rf(1, 16'h0000); wr_rf(2, 16'h0100);
      wr_im(0, insi(14, 3)); wr_im(1, ins(1, 1, 2, 1));
      wr_im(2, insi(13, 1)); wr_im(3, ins(15, 0, 0, 0));
      run(1'b0);
      rd_chk("t4_loop_r1", 1, 16'h0400);
      chk("t4_model_loopcnt", m_loop, 0);

      // pc wrap: preload loop_cnt=1, then BNZ to 0xFF, which wraps to 0x00
      wr_im(0, insi(14, 1)); wr_im(1, ins(15, 0, 0, 0));
      run(1'b0);
      wr_rf(1, 16'h0000);
      wr_im(0, insi(13, 12'h0FF)); wr_im(8'hFF, ins(1, 1, 2, 1));
      run(1'b0);
      chk("t6_done_cycle", mon_done_cyc, 9);
      rd_chk("t6_r1", 1, 16'h0100);
      wr_im(8'hFF, 16'hF000);

      // illegal opcode, start/host writes while busy, start in DONE
      wr_rf(15, 16'h5555);
      wr_im(0, ins(9, 0, 0, 0)); wr_im(1, ins(15, 0, 0, 0));
      run(1'b1);
      chk("t5_err_sticky", err, 1);
      rd_chk("t5_busy_wr_dropped", 15, 16'h5555);
      wr_im(0, ins(1, 1, 2, 3));
      run(1'b0);
      chk("t5_err_cleared", err, 0);
      rd_chk("t5_r3", 3, 16'h0200);

      // reset mid-run
      wr_rf(1, 16'h0000);
      wr_im(0, insi(14, 200)); wr_im(1, ins(1, 1, 2, 1));
      wr_im(2, insi(13, 1)); wr_im(3, ins(15, 0, 0, 0));
      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0;
      repeat (6) @(negedge clock);
      chk("t5_pre_rst_busy", busy, 1);
      reset = 1'b1;
      @(negedge clock);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_done", done, 0);
      reset = 1'b0;
      m_loop = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         chk("t5_post_rst_done", done, 0);
         chk("t5_post_rst_busy", busy, 0);
      end
      m_rf[1] = 16'h0100;
      rd_chk("t5_partial_r1", 1, 16'h0100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
